vga_dither_pipe: RTL and testbench

VGA_DITHER_PIPE -- requirements
Module: vga_dither_pipe

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_dither_quant.sv | 60 ++++++
 rtl/vga_dither_pipe.sv | 188 ++++++++++++++++++
 tb/tb_vga_dither_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing defaults, dither mode encodings,
// the 4x4 Bayer threshold matrix and the per-pixel delay-line tag.
`timescale 1ns/1ps
package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FRONT  = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BACK   = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FRONT  = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BACK   = 33;

   typedef enum logic [1:0] {
      DITHER_TRUNC       = 2'd0,
      DITHER_BAYER       = 2'd1,
      DITHER_BAYER_FRAME = 2'd2
   } dither_mode_e;

   // Row-major [y][x], flattened so the index is {y, x}
   localparam logic [3:0] BAYER_4X4 [16] = '{
      4'd0,  4'd8,  4'd2,  4'd10,
      4'd12, 4'd4,  4'd14, 4'd6,
      4'd3,  4'd11, 4'd1,  4'd9,
      4'd15, 4'd7,  4'd13, 4'd5
   };

   function automatic logic [3:0] bayer_threshold(input logic [1:0] y, input logic [1:0] x);
      return BAYER_4X4[{y, x}];
   endfunction

   // Sync flags hold "asserted" rather than pin level; polarity is applied at the output
   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       active;
      logic [1:0] x;
      logic [1:0] y;
      logic       frame_lsb;
   } pipe_tag_t;

endpackage

// File: rtl/vga_dither_quant.sv
// One colour channel: optional Bayer-threshold add, shift down to DAC width,
// saturate, blank outside the active area and register the result.
`timescale 1ns/1ps
module vga_dither_quant
   import vga_pkg::*;
#(
   parameter int IN_BITS  = 6,
   parameter int OUT_BITS = 2
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IN_BITS-1:0]  in_val,
   input  logic [3:0]          thresh,
   input  logic                dither_on,
   input  logic                active,
   output logic [OUT_BITS-1:0] q
);

   localparam int S = IN_BITS - OUT_BITS;

   logic [OUT_BITS-1:0] q_next;

   generate
      if (S == 0) begin : g_pass
         logic unused_thresh;
         assign unused_thresh = ^{thresh, dither_on};
         assign q_next = in_val;
      end else begin : g_quant
         logic [IN_BITS:0]  t_scaled;
         logic [IN_BITS:0]  sum;
         logic [OUT_BITS:0] shifted;

         // Threshold is rescaled so its full range spans one output step (2^S)
         if (S <= 4) begin : g_shr
            assign t_scaled = (IN_BITS+1)'(thresh >> (4 - S));
         end else begin : g_shl
            assign t_scaled = (IN_BITS+1)'({thresh, {(S-4){1'b0}}});
         end

         always_comb begin
            sum     = {1'b0, in_val} + (dither_on ? t_scaled : '0);
            shifted = (OUT_BITS+1)'(sum >> S);
            if (shifted > {1'b0, {OUT_BITS{1'b1}}}) begin
               q_next = '1;
            end else begin
               q_next = shifted[OUT_BITS-1:0];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else begin
         q <= active ? q_next : '0;
      end
   end

endmodule

// File: rtl/vga_dither_pipe.sv
// VGA timing generator with a renderer-latency-matched delay line and
// per-channel ordered dithering down to a narrow DAC.
`timescale 1ns/1ps
module vga_dither_pipe
   import vga_pkg::*;
#(
   parameter int H_ACTIVE    = VGA_H_ACTIVE,
   parameter int H_FRONT     = VGA_H_FRONT,
   parameter int H_SYNC      = VGA_H_SYNC,
   parameter int H_BACK      = VGA_H_BACK,
   parameter int V_ACTIVE    = VGA_V_ACTIVE,
   parameter int V_FRONT     = VGA_V_FRONT,
   parameter int V_SYNC      = VGA_V_SYNC,
   parameter int V_BACK      = VGA_V_BACK,
   parameter bit HSYNC_POL   = 1'b0,
   parameter bit VSYNC_POL   = 1'b0,
   parameter int IN_BITS     = 6,
   parameter int OUT_BITS    = 2,
   parameter int PIPE_LAT    = 1,
   parameter int DITHER_MODE = 2,
   parameter int FRAME_W     = 8,
   localparam int H_TOTAL    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
   localparam int V_TOTAL    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
   localparam int XW         = $clog2(H_TOTAL),
   localparam int YW         = $clog2(V_TOTAL)
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                dither_en,
   output logic [XW-1:0]       pixel_x,
   output logic [YW-1:0]       pixel_y,
   output logic                pix_active,
   output logic                line_start,
   output logic                frame_start,
   output logic [FRAME_W-1:0]  frame_num,
   input  logic [IN_BITS-1:0]  r_in,
   input  logic [IN_BITS-1:0]  g_in,
   input  logic [IN_BITS-1:0]  b_in,
   output logic                hsync,
   output logic                vsync,
   output logic [OUT_BITS-1:0] r_out,
   output logic [OUT_BITS-1:0] g_out,
   output logic [OUT_BITS-1:0] b_out
);

   localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] Y_LAST     = YW'(V_TOTAL - 1);
   localparam logic [XW:0]   X_ACT_END  = (XW+1)'(H_ACTIVE);
   localparam logic [XW:0]   HS_START   = (XW+1)'(H_ACTIVE + H_FRONT);
   localparam logic [XW:0]   HS_END     = (XW+1)'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [YW:0]   Y_ACT_END  = (YW+1)'(V_ACTIVE);
   localparam logic [YW:0]   VS_START   = (YW+1)'(V_ACTIVE + V_FRONT);
   localparam logic [YW:0]   VS_END     = (YW+1)'(V_ACTIVE + V_FRONT + V_SYNC);

   localparam bit DITHER_ACTIVE = (DITHER_MODE == int'(DITHER_BAYER)) ||
                                  (DITHER_MODE == int'(DITHER_BAYER_FRAME));
   localparam bit FRAME_PHASE   = (DITHER_MODE == int'(DITHER_BAYER_FRAME));

   logic        running;
   logic        x_wrap;
   logic        y_wrap;
   logic [XW:0] x_ext;
   logic [YW:0] y_ext;
   pipe_tag_t   raw_tag;
   pipe_tag_t   tap;
   logic [1:0]  bayer_x;
   logic [3:0]  thresh;
   logic        dither_on;

   assign x_wrap = (pixel_x == X_LAST);
   assign y_wrap = (pixel_y == Y_LAST);
   assign x_ext  = {1'b0, pixel_x};
   assign y_ext  = {1'b0, pixel_y};

   assign pix_active = (x_ext < X_ACT_END) && (y_ext < Y_ACT_END);

   // The first enabled edge after reset only arms the counter so that (0,0)
   // is presented as a real coordinate together with frame_start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pixel_x     <= '0;
         pixel_y     <= '0;
         frame_num   <= '0;
         running     <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (!running) begin
         running     <= 1'b1;
         line_start  <= 1'b1;
         frame_start <= 1'b1;
      end else begin
         line_start  <= x_wrap;
         frame_start <= x_wrap && y_wrap;
         if (x_wrap) begin
            pixel_x <= '0;
            if (y_wrap) begin
               pixel_y   <= '0;
               frame_num <= frame_num + 1'b1;
            end else begin
               pixel_y <= pixel_y + 1'b1;
            end
         end else begin
            pixel_x <= pixel_x + 1'b1;
         end
      end
   end

   // The armed-but-idle cycle feeds an inactive tag so no phantom pixel is emitted
   always_comb begin
      raw_tag = '0;
      if (running) begin
         raw_tag.hs        = (x_ext >= HS_START) && (x_ext < HS_END);
         raw_tag.vs        = (y_ext >= VS_START) && (y_ext < VS_END);
         raw_tag.active    = pix_active;
         raw_tag.x         = pixel_x[1:0];
         raw_tag.y         = pixel_y[1:0];
         raw_tag.frame_lsb = frame_num[0];
      end
   end

   generate
      if (PIPE_LAT == 0) begin : g_no_delay
         assign tap = raw_tag;
      end else begin : g_delay
         pipe_tag_t stages [PIPE_LAT];

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int i = 0; i < PIPE_LAT; i++) begin
                  stages[i] <= '0;
               end
            end else begin
               stages[0] <= raw_tag;
               for (int i = 1; i < PIPE_LAT; i++) begin
                  stages[i] <= stages[i-1];
               end
            end
         end

         assign tap = stages[PIPE_LAT-1];
      end
   endgenerate

   assign bayer_x   = FRAME_PHASE ? (tap.x ^ {tap.frame_lsb, tap.frame_lsb}) : tap.x;
   assign thresh    = bayer_threshold(tap.y, bayer_x);
   assign dither_on = dither_en && DITHER_ACTIVE;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hsync <= ~HSYNC_POL;
         vsync <= ~VSYNC_POL;
      end else begin
         hsync <= tap.hs ? HSYNC_POL : ~HSYNC_POL;
         vsync <= tap.vs ? VSYNC_POL : ~VSYNC_POL;
      end
   end

   vga_dither_quant #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_quant_r (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_val    (r_in),
      .thresh    (thresh),
      .dither_on (dither_on),
      .active    (tap.active),
      .q         (r_out)
   );

   vga_dither_quant #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_quant_g (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_val    (g_in),
      .thresh    (thresh),
      .dither_on (dither_on),
      .active    (tap.active),
      .q         (g_out)
   );

   vga_dither_quant #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_quant_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_val    (b_in),
      .thresh    (thresh),
      .dither_on (dither_on),
      .active    (tap.active),
      .q         (b_out)
   );

endmodule

// File: tb/tb_vga_dither_pipe.sv
// Directed bench: a default 640x480 instance for reset, dithering, sync and blanking,
// and a tiny-timing PIPE_LAT=3 instance for latency, vsync, frame phase and frame wrap.
`timescale 1ns/1ps
module tb_vga_dither_pipe;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, dither_en;
   logic [5:0] r_in, g_in, b_in;
   logic [9:0] pixel_x, pixel_y;
   logic       pix_active, line_start, frame_start, hsync, vsync;
   logic [7:0] frame_num;
   logic [1:0] r_out, g_out, b_out;

   logic       rst_s_n, dither_en_s;
   logic [5:0] r_s, g_s, b_s;
   logic [3:0] px_s;
   logic [2:0] py_s;
   logic       act_s, ls_s, fs_s, hs_s, vs_s;
   logic [7:0] fn_s;
   logic [1:0] ro_s, go_s, bo_s;

   int errors = 0;
   int checks = 0;
   int per    = 0;
   int per_s  = 0;

   vga_dither_pipe dut (
      .clk(clk), .rst_n(rst_n), .dither_en(dither_en),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .pix_active(pix_active),
      .line_start(line_start), .frame_start(frame_start), .frame_num(frame_num),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .hsync(hsync), .vsync(vsync), .r_out(r_out), .g_out(g_out), .b_out(b_out)
   );

   // 14 x 7 total, 8 x 4 active, hsync x=10..11, vsync y=5
   vga_dither_pipe #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .PIPE_LAT(3)
   ) dut_s (
      .clk(clk), .rst_n(rst_s_n), .dither_en(dither_en_s),
      .pixel_x(px_s), .pixel_y(py_s), .pix_active(act_s),
      .line_start(ls_s), .frame_start(fs_s), .frame_num(fn_s),
      .r_in(r_s), .g_in(g_s), .b_in(b_s),
      .hsync(hs_s), .vsync(vs_s), .r_out(ro_s), .g_out(go_s), .b_out(bo_s)
   );

   task step_to(input int p);
      while (per < p) begin
         @(posedge clk);
         #1;
         per = per + 1;
      end
   endtask

   task step_s_to(input int p);
      while (per_s < p) begin
         @(posedge clk);
         #1;
         per_s = per_s + 1;
      end
   endtask

   task test_reset();
      rst_n = 1'b0; dither_en = 1'b1;
      r_in = 6'd20; g_in = 6'd30; b_in = 6'd63;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({pixel_y, pixel_x} !== 20'd0) begin errors++; $display("[TB] FAIL reset_coord: got x=%0d y=%0d, want 0,0", pixel_x, pixel_y); end
      checks++; if (frame_num !== 8'd0) begin errors++; $display("[TB] FAIL reset_frame_num: got %0d, want 0", frame_num); end
      checks++; if ({line_start, frame_start} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulses: got %b, want 00", {line_start, frame_start}); end
      checks++; if ({hsync, vsync} !== 2'b11) begin errors++; $display("[TB] FAIL reset_sync: got %b, want 11", {hsync, vsync}); end
      checks++; if ({r_out, g_out, b_out} !== 6'd0) begin errors++; $display("[TB] FAIL reset_rgb: got %h, want 0", {r_out, g_out, b_out}); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1; per = 0;
      checks++; if ({pixel_y, pixel_x} !== 20'd0) begin errors++; $display("[TB] FAIL release_coord: got x=%0d y=%0d, want 0,0", pixel_x, pixel_y); end
      checks++; if ({line_start, frame_start} !== 2'b11) begin errors++; $display("[TB] FAIL release_pulses: got %b, want 11", {line_start, frame_start}); end
      step_to(1);
      checks++; if (pixel_x !== 10'd1) begin errors++; $display("[TB] FAIL count_x: got %0d, want 1", pixel_x); end
      checks++; if ({line_start, frame_start} !== 2'b00) begin errors++; $display("[TB] FAIL pulse_width: got %b, want 00", {line_start, frame_start}); end
   endtask

   // r=20, g=30, b=63 with thresholds 0,8,2,10 along row 0
   task test_dither_line0();
      int pe[4];
      int er[4];
      int eg[4];
      pe = '{2, 3, 4, 5};
      er = '{1, 1, 1, 1};
      eg = '{1, 2, 2, 2};
      for (int i = 0; i < 4; i++) begin
         step_to(pe[i]);
         checks++; if ({r_out, g_out, b_out} !== {2'(er[i]), 2'(eg[i]), 2'd3})
            begin errors++; $display("[TB] FAIL dither_row0_x%0d: got %0d/%0d/%0d, want %0d/%0d/3", i, r_out, g_out, b_out, er[i], eg[i]); end
      end
   endtask

   task test_timing_line0();
      step_to(639);
      checks++; if (pix_active !== 1'b1) begin errors++; $display("[TB] FAIL active_x639: got %b, want 1", pix_active); end
      step_to(640);
      checks++; if (pix_active !== 1'b0) begin errors++; $display("[TB] FAIL active_x640: got %b, want 0", pix_active); end
      step_to(657);
      checks++; if (hsync !== 1'b1) begin errors++; $display("[TB] FAIL hsync_x655: got %b, want 1", hsync); end
      step_to(658);
      checks++; if (hsync !== 1'b0) begin errors++; $display("[TB] FAIL hsync_x656: got %b, want 0", hsync); end
      step_to(702);
      checks++; if ({r_out, g_out, b_out} !== 6'd0) begin errors++; $display("[TB] FAIL blank_x700: got %h, want 0", {r_out, g_out, b_out}); end
      checks++; if (vsync !== 1'b1) begin errors++; $display("[TB] FAIL vsync_line0: got %b, want 1", vsync); end
      step_to(753);
      checks++; if (hsync !== 1'b0) begin errors++; $display("[TB] FAIL hsync_x751: got %b, want 0", hsync); end
      step_to(754);
      checks++; if (hsync !== 1'b1) begin errors++; $display("[TB] FAIL hsync_x752: got %b, want 1", hsync); end
      step_to(800);
      checks++; if ({line_start, pixel_x, pixel_y} !== {1'b1, 10'd0, 10'd1}) begin errors++; $display("[TB] FAIL line_wrap: got ls=%b x=%0d y=%0d, want 1,0,1", line_start, pixel_x, pixel_y); end
   endtask

   // (1,1) b=4, (2,1) b=14, (0,3) b=15, (3,3) b=5
   task test_dither_rows();
      int pe[4];
      int er[4];
      int eg[4];
      pe = '{803, 804, 2402, 2405};
      er = '{1, 2, 2, 1};
      eg = '{2, 2, 2, 2};
      for (int i = 0; i < 4; i++) begin
         step_to(pe[i]);
         checks++; if ({r_out, g_out, b_out} !== {2'(er[i]), 2'(eg[i]), 2'd3})
            begin errors++; $display("[TB] FAIL dither_period%0d: got %0d/%0d/%0d, want %0d/%0d/3", pe[i], r_out, g_out, b_out, er[i], eg[i]); end
      end
   endtask

   task test_truncate();
      int pe[7];
      pe = '{3210, 3211, 3212, 3213, 4807, 5602, 5603};
      step_to(3199);
      dither_en = 1'b0; r_in = 6'd63; g_in = 6'd20; b_in = 6'd15;
      for (int i = 0; i < 7; i++) begin
         step_to(pe[i]);
         checks++; if ({r_out, g_out, b_out} !== {2'd3, 2'd1, 2'd0})
            begin errors++; $display("[TB] FAIL truncate_period%0d: got %0d/%0d/%0d, want 3/1/0", pe[i], r_out, g_out, b_out); end
      end
   endtask

   task test_reset_midline();
      step_to(6700);
      checks++; if ({pixel_x, pixel_y, r_out} !== {10'd300, 10'd8, 2'd3}) begin errors++; $display("[TB] FAIL pre_reset: got x=%0d y=%0d r=%0d, want 300,8,3", pixel_x, pixel_y, r_out); end
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++; if ({pixel_x, pixel_y} !== 20'd0) begin errors++; $display("[TB] FAIL midreset_coord: got x=%0d y=%0d, want 0,0", pixel_x, pixel_y); end
      checks++; if ({hsync, vsync, r_out, g_out, b_out, frame_start} !== 9'b110000000) begin errors++; $display("[TB] FAIL midreset_outputs: got %b, want 110000000", {hsync, vsync, r_out, g_out, b_out, frame_start}); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1; per = 0;
      checks++; if ({frame_start, pixel_x, pixel_y} !== {1'b1, 20'd0}) begin errors++; $display("[TB] FAIL midreset_release: got fs=%b x=%0d y=%0d, want 1,0,0", frame_start, pixel_x, pixel_y); end
      step_to(1);
      checks++; if (r_out !== 2'd0) begin errors++; $display("[TB] FAIL no_phantom_pixel: got %0d, want 0", r_out); end
      step_to(2);
      checks++; if (r_out !== 2'd3) begin errors++; $display("[TB] FAIL first_pixel_after_reset: got %0d, want 3", r_out); end
   endtask

   task test_pipe3_frame0();
      @(negedge clk); rst_s_n = 1'b1;
      @(posedge clk); #1; per_s = 0;
      step_s_to(4);
      checks++; if ({ro_s, go_s} !== {2'd1, 2'd1}) begin errors++; $display("[TB] FAIL s_f0_x0y0: got %0d/%0d, want 1/1", ro_s, go_s); end
      step_s_to(7);
      checks++; if ({ro_s, go_s} !== {2'd2, 2'd1}) begin errors++; $display("[TB] FAIL s_f0_x3y0: got %0d/%0d, want 2/1", ro_s, go_s); end
      step_s_to(13);
      checks++; if ({hs_s, ro_s, bo_s} !== {1'b1, 4'd0}) begin errors++; $display("[TB] FAIL s_blank_x9: got hs=%b r=%0d b=%0d, want 1,0,0", hs_s, ro_s, bo_s); end
      step_s_to(14);
      checks++; if (hs_s !== 1'b0) begin errors++; $display("[TB] FAIL s_hsync_x10: got %b, want 0", hs_s); end
      step_s_to(15);
      checks++; if (hs_s !== 1'b0) begin errors++; $display("[TB] FAIL s_hsync_x11: got %b, want 0", hs_s); end
      step_s_to(16);
      checks++; if (hs_s !== 1'b1) begin errors++; $display("[TB] FAIL s_hsync_x12: got %b, want 1", hs_s); end
      step_s_to(46);
      checks++; if ({ro_s, go_s} !== {2'd2, 2'd2}) begin errors++; $display("[TB] FAIL s_f0_x0y3: got %0d/%0d, want 2/2", ro_s, go_s); end
   endtask

   task test_pipe3_vsync_frame1();
      step_s_to(73);
      checks++; if (vs_s !== 1'b1) begin errors++; $display("[TB] FAIL s_vsync_y4: got %b, want 1", vs_s); end
      step_s_to(74);
      checks++; if (vs_s !== 1'b0) begin errors++; $display("[TB] FAIL s_vsync_y5_start: got %b, want 0", vs_s); end
      step_s_to(87);
      checks++; if (vs_s !== 1'b0) begin errors++; $display("[TB] FAIL s_vsync_y5_end: got %b, want 0", vs_s); end
      step_s_to(88);
      checks++; if (vs_s !== 1'b1) begin errors++; $display("[TB] FAIL s_vsync_y6: got %b, want 1", vs_s); end
      step_s_to(97);
      checks++; if ({fs_s, fn_s} !== {1'b0, 8'd0}) begin errors++; $display("[TB] FAIL s_frame_end: got fs=%b fn=%0d, want 0,0", fs_s, fn_s); end
      step_s_to(98);
      checks++; if ({fs_s, fn_s, px_s, py_s} !== {1'b1, 8'd1, 7'd0}) begin errors++; $display("[TB] FAIL s_frame1_start: got fs=%b fn=%0d x=%0d y=%0d, want 1,1,0,0", fs_s, fn_s, px_s, py_s); end
      step_s_to(102);
      checks++; if ({ro_s, go_s} !== {2'd2, 2'd1}) begin errors++; $display("[TB] FAIL s_f1_x0y0: got %0d/%0d, want 2/1", ro_s, go_s); end
      step_s_to(144);
      checks++; if ({ro_s, go_s} !== {2'd1, 2'd1}) begin errors++; $display("[TB] FAIL s_f1_x0y3: got %0d/%0d, want 1/1", ro_s, go_s); end
   endtask

   task test_frame_wrap();
      step_s_to(24990);
      checks++; if (fn_s !== 8'd255) begin errors++; $display("[TB] FAIL s_frame255: got %0d, want 255", fn_s); end
      step_s_to(25087);
      checks++; if ({fs_s, fn_s} !== {1'b0, 8'd255}) begin errors++; $display("[TB] FAIL s_pre_wrap: got fs=%b fn=%0d, want 0,255", fs_s, fn_s); end
      step_s_to(25088);
      checks++; if ({fs_s, fn_s} !== {1'b1, 8'd0}) begin errors++; $display("[TB] FAIL s_frame_wrap: got fs=%b fn=%0d, want 1,0", fs_s, fn_s); end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      rst_s_n = 1'b0; dither_en_s = 1'b1;
      r_s = 6'd22; g_s = 6'd20; b_s = 6'd63;
      test_reset();
      test_dither_line0();
      test_timing_line0();
      test_dither_rows();
      test_truncate();
      test_reset_midline();
      test_pipe3_frame0();
      test_pipe3_vsync_frame1();
      test_frame_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
